wishbone_slave_regfile: RTL and testbench

Wishbone classic (non-pipelined) responder holding a small bank of 32-bit read/write registers. It is the slave end of the bus driven by our wishbone master: it decodes `addr_i`, inserts a configurable number of wait states, and answers each `cyc_i`/`stb_i` request with exactly one `ack_o` pulse. It tolerates masters that keep `cyc_i`/`stb_i` asserted after the acknowledge, and exposes all register contents to surrounding logic (LEDs, debug) through a flat output bus.

---
 rtl/wishbone_slave_regfile_if.sv | 21 ++
 rtl/wishbone_slave_regfile.sv | 133 +++++++++++++
 tb/tb_wishbone_slave_regfile.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_slave_regfile_if.sv
// Wishbone classic bus bundle between one master and the register-file responder.
// Signal names follow the responder's point of view (_i into the slave, _o out of it).
interface wishbone_slave_regfile_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, addr_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, data_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/wishbone_slave_regfile.sv
// Wishbone classic responder: a bank of 32-bit registers with programmable wait states,
// one ack per request, and every register mirrored onto a flat output bus.
module wishbone_slave_regfile #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  wishbone_slave_regfile_if.slave   bus,
  output logic [32*NUM_REGS-1:0]    regs_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q;
  logic [31:0]   regFile_q [NUM_REGS];

  logic          req;
  logic          goAck;
  logic          selWe;
  logic [31:0]   selAddr;
  logic [31:0]   selData;
  logic [31:0]   offs;
  logic          inRange;
  logic          wrEn;
  logic [IW-1:0] idx;

  assign req = bus.cyc_i & bus.stb_i;

  // With zero wait states ACK is entered straight from IDLE, before the latches hold the request.
  assign selAddr = (state_q == ST_IDLE) ? bus.addr_i : addr_q;
  assign selWe   = (state_q == ST_IDLE) ? bus.we_i   : we_q;
  assign selData = (state_q == ST_IDLE) ? bus.data_i : wdata_q;

  assign offs    = selAddr - ADDR_BASE;
  assign inRange = offs < 32'(NUM_REGS * 4);
  assign idx     = offs[IW+1:2];
  assign wrEn    = goAck & selWe & inRange;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    goAck     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          waitCnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
            goAck   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d   = ST_IDLE;
          waitCnt_d = 4'd0;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
          if (waitCnt_q == 4'd1) begin
            state_d = ST_ACK;
            goAck   = 1'b1;
          end
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (goAck && !selWe) begin
      rdata_d = inRange ? regFile_q[idx] : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 4'd0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      ack_q     <= goAck;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
    end else if (state_q == ST_IDLE && req) begin
      addr_q  <= bus.addr_i;
      we_q    <= bus.we_i;
      wdata_q <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regFile_q[k] <= 32'h0;
      end
    end else if (wrEn) begin
      regFile_q[idx] <= selData;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : gRegsOut
    assign regs_o[32*g +: 32] = regFile_q[g];
  end

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// Scoreboard bench for wishbone_slave_regfile: three instances cover the default setup,
// zero wait states with a non-zero base address, and three wait states.
module tb_wishbone_slave_regfile;

  logic clk = 1'b0;
  logic rst_n;
  int   cycleNo = 0;
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  wishbone_slave_regfile_if bus0 ();
  wishbone_slave_regfile_if bus1 ();
  wishbone_slave_regfile_if bus2 ();
  logic [255:0] regs0, regs1, regs2;

  wishbone_slave_regfile #(.ADDR_BASE(32'h0), .NUM_REGS(8), .WAIT_CYCLES(1)) u0 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus0), .regs_o(regs0));
  wishbone_slave_regfile #(.ADDR_BASE(32'h100), .NUM_REGS(8), .WAIT_CYCLES(0)) u1 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus1), .regs_o(regs1));
  wishbone_slave_regfile #(.ADDR_BASE(32'h0), .NUM_REGS(8), .WAIT_CYCLES(3)) u2 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus2), .regs_o(regs2));

  typedef struct {
    int          inst;
    int          ackCycle;
    bit          isRead;
    logic [31:0] data;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] expRegs [3][8];
  logic [31:0] lastRead [3];

  function automatic int waitOf(input int id);
    return (id == 1) ? 0 : (id == 2) ? 3 : 1;
  endfunction

  function automatic logic [31:0] baseOf(input int id);
    return (id == 1) ? 32'h100 : 32'h0;
  endfunction

  function automatic logic [31:0] getReg(input int id, input int k);
    case (id)
      0:       return regs0[k*32 +: 32];
      1:       return regs1[k*32 +: 32];
      default: return regs2[k*32 +: 32];
    endcase
  endfunction

  function automatic logic [31:0] getData(input int id);
    case (id)
      0:       return bus0.data_o;
      1:       return bus1.data_o;
      default: return bus2.data_o;
    endcase
  endfunction

  function automatic logic getAck(input int id);
    case (id)
      0:       return bus0.ack_o;
      1:       return bus1.ack_o;
      default: return bus2.ack_o;
    endcase
  endfunction

  task automatic setBus(input int id, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] data);
    case (id)
      0: begin bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we; bus0.addr_i = addr; bus0.data_i = data; end
      1: begin bus1.cyc_i = cyc; bus1.stb_i = stb; bus1.we_i = we; bus1.addr_i = addr; bus1.data_i = data; end
      default: begin bus2.cyc_i = cyc; bus2.stb_i = stb; bus2.we_i = we; bus2.addr_i = addr; bus2.data_i = data; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Registers and held read data of one instance against the model.
  task automatic checkState(input int id);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("u%0d regs_o[%0d]", id, k), getReg(id, k), expRegs[id][k]);
    end
    checkOutput($sformatf("u%0d data_o held", id), getData(id), lastRead[id]);
  endtask

  task automatic handleAck(input int id);
    int   found;
    exp_t e;
    found = -1;
    foreach (sbQ[j]) begin
      if (found < 0 && sbQ[j].inst == id) found = j;
    end
    if (found < 0) begin
      checkCount++;
      $display("[TB] FAIL u%0d unexpected ack at cycle %0d: got ack 1, expected 0", id, cycleNo);
    end else begin
      e = sbQ[found];
      sbQ.delete(found);
      checkOutput($sformatf("u%0d ack cycle", id), 32'(cycleNo), 32'(e.ackCycle));
      if (e.isRead) checkOutput($sformatf("u%0d read data", id), getData(id), e.data);
    end
  endtask

  // Monitor: every ack seen on any instance must match the oldest pending expectation for it.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (getAck(i) === 1'b1) handleAck(i);
    end
  end

  // One complete transfer; holdExtra > 0 keeps the request up after the ack with scrambled inputs.
  task automatic applyStimulus(input int id, input bit we, input logic [31:0] addr,
                               input logic [31:0] data, input int holdExtra);
    exp_t        e;
    logic [31:0] offs;
    logic [31:0] expData;
    int          w;
    w       = waitOf(id);
    offs    = addr - baseOf(id);
    expData = 32'h0;
    if (we) begin
      if (offs < 32) expRegs[id][offs[4:2]] = data;
      expData = lastRead[id];
    end else begin
      expData = (offs < 32) ? expRegs[id][offs[4:2]] : 32'h0;
      lastRead[id] = expData;
    end
    e.inst = id; e.ackCycle = cycleNo + 1 + w; e.isRead = !we; e.data = expData;
    sbQ.push_back(e);
    setBus(id, 1'b1, 1'b1, we, addr, data);
    repeat (w + 1) @(negedge clk);
    if (holdExtra > 0) begin
      setBus(id, 1'b1, 1'b1, we, ~addr, ~data);
      repeat (holdExtra) @(negedge clk);
    end
    setBus(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat ((holdExtra > 0) ? 1 : 2) @(negedge clk);
    checkState(id);
  endtask

  // Request that loses stb_i after dropAfter cycles, before the ack would be issued.
  task automatic abortStim(input int id, input logic [31:0] addr, input logic [31:0] data,
                           input int dropAfter);
    setBus(id, 1'b1, 1'b1, 1'b1, addr, data);
    repeat (dropAfter) @(negedge clk);
    setBus(id, 1'b1, 1'b0, 1'b1, addr, data);
    repeat (3) @(negedge clk);
    setBus(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkState(id);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      lastRead[i] = 32'h0;
      for (int k = 0; k < 8; k++) expRegs[i][k] = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) setBus(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("u%0d reset ack", i), 32'(getAck(i)), 32'h0);
      checkState(i);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Default instance: basic write/read, sticky master, out of range, unaligned, boundary abort.
    applyStimulus(0, 1'b1, 32'h8,  32'hCAFE_F00D, 0);
    applyStimulus(0, 1'b0, 32'h8,  32'h0, 0);
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 10);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 0);
    applyStimulus(0, 1'b1, 32'h20, 32'h0000_1234, 0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 0);
    applyStimulus(0, 1'b1, 32'hB,  32'h5A5A_5A5A, 0);
    applyStimulus(0, 1'b0, 32'h8,  32'h0, 0);
    abortStim(0, 32'h0, 32'h0000_1111, 1);

    // Zero wait states, base 0x100: address 0 wraps far out of range.
    applyStimulus(1, 1'b1, 32'h100, 32'h0000_00A5, 0);
    applyStimulus(1, 1'b0, 32'h0,   32'h0, 0);
    applyStimulus(1, 1'b0, 32'h100, 32'h0, 0);
    applyStimulus(1, 1'b1, 32'h11C, 32'h8000_0001, 2);
    applyStimulus(1, 1'b0, 32'h11C, 32'h0, 0);

    // Three wait states, including an abort in the middle of WAIT.
    applyStimulus(2, 1'b1, 32'hC, 32'h0000_0077, 0);
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 0);
    abortStim(2, 32'hC, 32'h0000_0099, 2);
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 0);

    // Reset while a write sits in WAIT.
    setBus(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clearModel();
    checkOutput("u0 ack during reset", 32'(getAck(0)), 32'h0);
    for (int i = 0; i < 3; i++) checkState(i);
    setBus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h4, 32'h0, 0);
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 0);
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
